// File: rtl/noc_arb_cmd_pkg.sv
// Shared definitions for the arbiter command driver: command codes, port
// indices, FSM state encoding and a port one-hot helper.
package noc_arb_cmd_pkg;

    localparam int NPORT = 5;

    localparam logic [2:0] PORT_L = 3'd0;
    localparam logic [2:0] PORT_N = 3'd1;
    localparam logic [2:0] PORT_E = 3'd2;
    localparam logic [2:0] PORT_W = 3'd3;
    localparam logic [2:0] PORT_S = 3'd4;

    localparam logic [5:0] NOREQ1 = 6'd1;
    localparam logic [5:0] REQFL  = 6'd2,  REQFN  = 6'd3,  REQFE  = 6'd4,  REQFW  = 6'd5,  REQFS  = 6'd6;
    localparam logic [5:0] NOREQ7 = 6'd7;
    localparam logic [5:0] REQFLN = 6'd8,  REQFLE = 6'd9,  REQFLW = 6'd10, REQFLS = 6'd11, REQFLL = 6'd12;
    localparam logic [5:0] REQFNE = 6'd13, REQFNW = 6'd14, REQFNS = 6'd15, REQFNL = 6'd16, REQFNN = 6'd17;
    localparam logic [5:0] REQFEW = 6'd18, REQFES = 6'd19, REQFEL = 6'd20, REQFEN = 6'd21, REQFEE = 6'd22;
    localparam logic [5:0] REQFWS = 6'd23, REQFWL = 6'd24, REQFWN = 6'd25, REQFWE = 6'd26, REQFWW = 6'd27;
    localparam logic [5:0] REQFSL = 6'd28, REQFSN = 6'd29, REQFSE = 6'd30, REQFSW = 6'd31, REQFSS = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_DONE
    } state_e;

    function automatic logic [4:0] port_onehot(input logic [2:0] p);
        return 5'b00001 << p;
    endfunction

endpackage

// File: rtl/arb_cmd_decode.sv
// Combinational decode of a request-scenario command into a legality flag,
// the number of requests and the two port indices.
module arb_cmd_decode
    import noc_arb_cmd_pkg::*;
(
    input  logic [5:0] cmd_i,
    output logic       valid_o,
    output logic [1:0] nreq_o,
    output logic [2:0] first_o,
    output logic [2:0] second_o
);

    logic [5:0] k;
    logic [5:0] sum;

    always_comb begin
        valid_o  = 1'b0;
        nreq_o   = 2'd0;
        first_o  = PORT_L;
        second_o = PORT_L;
        k        = cmd_i - REQFLN;
        // pair codes: first = k/5, second = first + 1 + k%5 wrapped to 0..4
        sum      = (k / 6'd5) + (k % 6'd5) + 6'd1;
        if (cmd_i == NOREQ1 || cmd_i == NOREQ7) begin
            valid_o = 1'b1;
        end else if (cmd_i >= REQFL && cmd_i <= REQFS) begin
            valid_o = 1'b1;
            nreq_o  = 2'd1;
            first_o = 3'(cmd_i - REQFL);
        end else if (cmd_i >= REQFLN && cmd_i <= REQFSS) begin
            valid_o  = 1'b1;
            nreq_o   = 2'd2;
            first_o  = 3'(k / 6'd5);
            second_o = (sum >= 6'd5) ? 3'(sum - 6'd5) : 3'(sum);
        end
    end

endmodule

// File: rtl/arb_cmd_driver.sv
// Executes one request-scenario command against the round-robin arbiter:
// drives req lines, logs grants, and pulses done on completion or abort.
//   state   | meaning
//   IDLE    | cmd_ready high, waiting for a command
//   REQ     | requests driven, waiting for grants (timeout armed)
//   GAP     | one cycle with requests low before a same-port re-request
//   DONE    | done/err pulse, back to IDLE
module arb_cmd_driver
    import noc_arb_cmd_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cmd,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [4:0] arb_req,
    input  logic [4:0] arb_gnt,
    output logic       done,
    output logic       err,
    output logic [2:0] gnt_first,
    output logic [2:0] gnt_second,
    output logic [1:0] gnt_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [4:0]      req_q, req_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [2:0]      first_q, first_d;
    logic [2:0]      second_q, second_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            same_q, same_d;
    logic [2:0]      port_q, port_d;

    logic            dec_valid;
    logic [1:0]      dec_nreq;
    logic [2:0]      dec_first;
    logic [2:0]      dec_second;
    logic [4:0]      eff_gnt;
    logic            gnt_hit;
    logic [2:0]      gnt_idx;

    arb_cmd_decode u_decode (
        .cmd_i    (cmd),
        .valid_o  (dec_valid),
        .nreq_o   (dec_nreq),
        .first_o  (dec_first),
        .second_o (dec_second)
    );

    assign eff_gnt = arb_gnt & req_q;

    always_comb begin
        gnt_hit = |eff_gnt;
        gnt_idx = 3'd0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (eff_gnt[i]) gnt_idx = 3'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        err_d    = err_q;
        first_d  = first_q;
        second_d = second_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        same_d   = same_q;
        port_d   = port_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    err_d    = 1'b0;
                    first_d  = 3'd0;
                    second_d = 3'd0;
                    cnt_d    = 2'd0;
                    tmr_d    = TMR_LOAD;
                    if (!dec_valid) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (dec_nreq == 2'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                        same_d  = (dec_nreq == 2'd2) && (dec_second == dec_first);
                        port_d  = dec_first;
                        req_d   = port_onehot(dec_first);
                        if (dec_nreq == 2'd2 && dec_second != dec_first)
                            req_d = req_d | port_onehot(dec_second);
                    end
                end
            end
            ST_REQ: begin
                if (gnt_hit) begin
                    req_d = req_q & ~port_onehot(gnt_idx);
                    if (cnt_q == 2'd0) first_d = gnt_idx;
                    else               second_d = gnt_idx;
                    cnt_d = cnt_q + 2'd1;
                    tmr_d = TMR_LOAD;
                    if (req_d == 5'd0) state_d = same_q ? ST_GAP : ST_DONE;
                end else if (tmr_q == '0) begin
                    err_d   = 1'b1;
                    req_d   = 5'd0;
                    same_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_GAP: begin
                req_d   = port_onehot(port_q);
                same_d  = 1'b0;
                tmr_d   = TMR_LOAD;
                state_d = ST_REQ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            req_q    <= 5'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            first_q  <= 3'd0;
            second_q <= 3'd0;
            cnt_q    <= 2'd0;
            tmr_q    <= '0;
            same_q   <= 1'b0;
            port_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            done_q   <= done_d;
            err_q    <= err_d;
            first_q  <= first_d;
            second_q <= second_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            same_q   <= same_d;
            port_q   <= port_d;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign arb_req    = req_q;
    assign done       = done_q;
    assign err        = err_q;
    assign gnt_first  = first_q;
    assign gnt_second = second_q;
    assign gnt_cnt    = cnt_q;

endmodule

// File: tb/tb_arb_cmd_driver.sv
// Bench for arb_cmd_driver: a table of directed commands, hand-timed corner
// sequences, then randomized commands and grants against a behavioural model.
module tb_arb_cmd_driver;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] cmd = 6'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] arb_req;
    logic [4:0] arb_gnt = 5'd0;
    logic       done;
    logic       err;
    logic [2:0] gnt_first;
    logic [2:0] gnt_second;
    logic [1:0] gnt_cnt;

    int vectors = 0;
    int miscompares = 0;

    arb_cmd_driver #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .arb_req    (arb_req),
        .arb_gnt    (arb_gnt),
        .done       (done),
        .err        (err),
        .gnt_first  (gnt_first),
        .gnt_second (gnt_second),
        .gnt_cnt    (gnt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] c;
        logic [4:0] g;
        logic [4:0] req0;
        bit         e;
        int         n;
        int         f;
        int         s;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [4:0] v);
        int r = 0;
        for (int i = 4; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Command meaning straight from the code rules: none, single, or pair.
    function automatic void ref_decode(input int c, output bit legal, output int n,
                                       output int p0, output int p1);
        legal = 1'b1; n = 0; p0 = 0; p1 = 0;
        if (c == 1 || c == 7) begin
            n = 0;
        end else if (c >= 2 && c <= 6) begin
            n = 1; p0 = c - 2;
        end else if (c >= 8 && c <= 32) begin
            n = 2; p0 = (c - 8) / 5; p1 = (p0 + 1 + (c - 8) % 5) % 5;
        end else begin
            legal = 1'b0;
        end
    endfunction

    // Called #1 after a rising edge; returns #1 after the acceptance edge.
    task automatic send(input logic [5:0] c);
        int w = 0;
        while (!cmd_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("cmd_ready_before_send", int'(cmd_ready), 1);
        cmd = c; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = 6'($urandom);
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic run_rand(input logic [5:0] c, input bit starve);
        bit legal, pend, gap, ed, ee;
        int n, p0, p1, ps, waitc, cyc, g;
        int mask;
        int log[$];
        logic [4:0] eff;
        ref_decode(int'(c), legal, n, p0, p1);
        send(c);
        mask = 0; pend = 0; gap = 0; ps = p0; waitc = 0; ed = 0; ee = 0; cyc = 0;
        if (!legal) begin
            ed = 1; ee = 1;
        end else if (n == 0) begin
            ed = 1;
        end else begin
            mask = 1 << p0;
            if (n == 2) begin
                if (p1 != p0) mask = mask | (1 << p1);
                else pend = 1;
            end
        end
        while (cyc < 60) begin
            chk("rnd_arb_req", int'(arb_req), mask);
            chk("rnd_done", int'(done), int'(ed));
            if (ed) break;
            arb_gnt = starve ? 5'd0 : (($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0);
            step();
            cyc++;
            if (gap) begin
                gap = 0; mask = 1 << ps; pend = 0; waitc = 0;
            end else begin
                eff = arb_gnt & 5'(mask);
                if (eff != 5'd0) begin
                    g = lowest(eff);
                    log.push_back(g);
                    mask = mask & ~(1 << g);
                    waitc = 0;
                    if (mask == 0) begin
                        if (pend) gap = 1;
                        else ed = 1;
                    end
                end else begin
                    waitc++;
                    if (waitc == TIMEOUT) begin
                        ed = 1; ee = 1; mask = 0;
                    end
                end
            end
        end
        arb_gnt = 5'd0;
        if (!ed) begin
            vectors++; miscompares++;
            $display("FAIL rnd_bound: cmd %0d got no completion within 60 cycles", c);
        end
        chk("rnd_err", int'(err), int'(ee));
        chk("rnd_gnt_cnt", int'(gnt_cnt), log.size());
        if (log.size() >= 1) chk("rnd_gnt_first", int'(gnt_first), log[0]);
        if (log.size() >= 2) chk("rnd_gnt_second", int'(gnt_second), log[1]);
        chk("rnd_ready_low_in_done", int'(cmd_ready), 0);
        step();
        chk("rnd_done_one_cycle", int'(done), 0);
        chk("rnd_ready_after", int'(cmd_ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        tbl[0]  = '{6'd1,  5'h00, 5'h00, 1'b0, 0, -1, -1};
        tbl[1]  = '{6'd7,  5'h1f, 5'h00, 1'b0, 0, -1, -1};
        tbl[2]  = '{6'd0,  5'h00, 5'h00, 1'b1, 0, -1, -1};
        tbl[3]  = '{6'd40, 5'h1f, 5'h00, 1'b1, 0, -1, -1};
        tbl[4]  = '{6'd63, 5'h00, 5'h00, 1'b1, 0, -1, -1};
        tbl[5]  = '{6'd33, 5'h1f, 5'h00, 1'b1, 0, -1, -1};
        tbl[6]  = '{6'd4,  5'h1f, 5'h04, 1'b0, 1,  2, -1};
        tbl[7]  = '{6'd8,  5'h1f, 5'h03, 1'b0, 2,  0,  1};
        tbl[8]  = '{6'd28, 5'h1f, 5'h11, 1'b0, 2,  0,  4};
        tbl[9]  = '{6'd12, 5'h1f, 5'h01, 1'b0, 2,  0,  0};
        tbl[10] = '{6'd32, 5'h1f, 5'h10, 1'b0, 2,  4,  4};
        tbl[11] = '{6'd17, 5'h1f, 5'h02, 1'b0, 2,  1,  1};
        tbl[12] = '{6'd6,  5'h00, 5'h10, 1'b1, 0, -1, -1};
        tbl[13] = '{6'd8,  5'h02, 5'h03, 1'b1, 1,  1, -1};
        tbl[14] = '{6'd20, 5'h1f, 5'h05, 1'b0, 2,  0,  2};
        tbl[15] = '{6'd31, 5'h1f, 5'h18, 1'b0, 2,  3,  4};

        #3;
        chk("rst_arb_req", int'(arb_req), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_gnt_first", int'(gnt_first), 0);
        chk("rst_gnt_second", int'(gnt_second), 0);
        chk("rst_gnt_cnt", int'(gnt_cnt), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        #9 rst = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            send(tbl[i].c);
            chk("tbl_req0", int'(arb_req), int'(tbl[i].req0));
            arb_gnt = tbl[i].g;
            w = 0;
            while (!done && w < 40) begin
                step(); w++;
            end
            chk("tbl_done", int'(done), 1);
            chk("tbl_err", int'(err), int'(tbl[i].e));
            chk("tbl_gnt_cnt", int'(gnt_cnt), tbl[i].n);
            chk("tbl_req_cleared", int'(arb_req), 0);
            if (tbl[i].f >= 0) chk("tbl_gnt_first", int'(gnt_first), tbl[i].f);
            if (tbl[i].s >= 0) chk("tbl_gnt_second", int'(gnt_second), tbl[i].s);
            arb_gnt = 5'd0;
            step();
            chk("tbl_done_drop", int'(done), 0);
        end

        // NOREQ1: done on the edge right after acceptance, one cycle wide
        send(6'd1);
        chk("noreq_done", int'(done), 1);
        chk("noreq_req", int'(arb_req), 0);
        step();
        chk("noreq_done_drop", int'(done), 0);
        chk("noreq_ready", int'(cmd_ready), 1);

        // REQFE: grant after two idle cycles
        send(6'd4);
        chk("fe_req", int'(arb_req), 5'h04);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("fe_req_hold", int'(arb_req), 5'h04);
            chk("fe_no_done", int'(done), 0);
        end
        arb_gnt = 5'h04;
        step();
        arb_gnt = 5'd0;
        chk("fe_req_drop", int'(arb_req), 0);
        chk("fe_done", int'(done), 1);
        chk("fe_first", int'(gnt_first), 2);
        chk("fe_cnt", int'(gnt_cnt), 1);
        step();

        // REQFLN with a spurious grant on an unrequested port
        send(6'd8);
        chk("ln_req", int'(arb_req), 5'h03);
        arb_gnt = 5'h10; step();
        chk("ln_spurious_req", int'(arb_req), 5'h03);
        chk("ln_spurious_done", int'(done), 0);
        arb_gnt = 5'h02; step();
        chk("ln_req_after_n", int'(arb_req), 5'h01);
        arb_gnt = 5'h01; step();
        arb_gnt = 5'd0;
        chk("ln_done", int'(done), 1);
        chk("ln_first", int'(gnt_first), 1);
        chk("ln_second", int'(gnt_second), 0);
        chk("ln_cnt", int'(gnt_cnt), 2);
        step();

        // REQFLL: grant, one-cycle gap, re-request, grant
        send(6'd12);
        chk("ll_req", int'(arb_req), 5'h01);
        arb_gnt = 5'h01; step();
        arb_gnt = 5'd0;
        chk("ll_gap_req", int'(arb_req), 0);
        chk("ll_gap_done", int'(done), 0);
        step();
        chk("ll_rereq", int'(arb_req), 5'h01);
        arb_gnt = 5'h01; step();
        arb_gnt = 5'd0;
        chk("ll_done", int'(done), 1);
        chk("ll_cnt", int'(gnt_cnt), 2);
        chk("ll_first", int'(gnt_first), 0);
        chk("ll_second", int'(gnt_second), 0);
        step();

        // REQFS never granted: abort after TIMEOUT cycles in REQ
        send(6'd6);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step();
            chk("to_waiting_done", int'(done), 0);
            chk("to_waiting_req", int'(arb_req), 5'h10);
        end
        step();
        chk("to_done", int'(done), 1);
        chk("to_err", int'(err), 1);
        chk("to_req", int'(arb_req), 0);
        step();

        // Reset in the middle of REQFSW, then REQFWW runs normally
        send(6'd31);
        chk("rs_req", int'(arb_req), 5'h18);
        #3 rst = 1'b0;
        #1;
        chk("rs_arb_req", int'(arb_req), 0);
        chk("rs_done", int'(done), 0);
        chk("rs_err", int'(err), 0);
        chk("rs_cnt", int'(gnt_cnt), 0);
        chk("rs_first", int'(gnt_first), 0);
        chk("rs_second", int'(gnt_second), 0);
        chk("rs_ready", int'(cmd_ready), 1);
        arb_gnt = 5'h1f;
        #2 rst = 1'b1;
        step();
        step();
        chk("rs_after_cnt", int'(gnt_cnt), 0);
        chk("rs_after_req", int'(arb_req), 0);
        chk("rs_after_done", int'(done), 0);
        arb_gnt = 5'd0;
        send(6'd27);
        chk("ww_req", int'(arb_req), 5'h08);
        arb_gnt = 5'h08; step();
        arb_gnt = 5'd0;
        chk("ww_gap", int'(arb_req), 0);
        step();
        chk("ww_rereq", int'(arb_req), 5'h08);
        arb_gnt = 5'h08; step();
        arb_gnt = 5'd0;
        chk("ww_done", int'(done), 1);
        chk("ww_cnt", int'(gnt_cnt), 2);
        chk("ww_first", int'(gnt_first), 3);
        chk("ww_second", int'(gnt_second), 3);
        step();

        for (int i = 0; i < 150; i++) begin
            logic [5:0] c;
            c = ($urandom_range(0, 9) < 8) ? 6'($urandom_range(1, 32)) : 6'($urandom);
            run_rand(c, $urandom_range(0, 19) == 0);
            for (int j = $urandom_range(0, 2); j > 0; j--) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
